// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared BCP sizing parameters, FSM state type and variable index type
//
// Purpose: common definitions for the BCP unit blocks.
// Ports:   none (package).
package bcp_pkg;

  localparam int VAR_NUM        = 8;
  localparam int VAR_NUM_LOG    = 3;
  localparam int CLAUSE_NUM     = 8;
  localparam int CLAUSE_NUM_LOG = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE,
    CONFLICT
  } iw_state_t;

  typedef logic [VAR_NUM_LOG-1:0] var_idx_t;

endpackage

// File: rtl/implication_writer_if.sv
// rtl/implication_writer_if.sv - implication/assignment/FAT/status bundle of the implication writer
//
// Purpose: groups the implication writer's bus signals.
// Signals:
//   start, imp_valid, imp_var, imp_val   - round start and per-clause implications
//   asg_valid, asg_val                   - current variable assignment
//   fat_full                             - FAT back-pressure
//   fat_en, fat_write, fat_in, fat_val   - FAT write port
//   busy, done, conflict                 - round status
//   conflict_clause, imp_count           - round results, held until the next start
// Modports:
//   master - BCP controller side (drives start/implications/assignment/fat_full)
//   slave  - implication writer side
interface implication_writer_if;
  import bcp_pkg::*;

  logic                                start;
  logic [CLAUSE_NUM-1:0]               imp_valid;
  logic [CLAUSE_NUM*VAR_NUM_LOG-1:0]   imp_var;
  logic [CLAUSE_NUM-1:0]               imp_val;
  logic [VAR_NUM-1:0]                  asg_valid;
  logic [VAR_NUM-1:0]                  asg_val;
  logic                                fat_full;
  logic                                fat_en;
  logic                                fat_write;
  var_idx_t                            fat_in;
  logic                                fat_val;
  logic                                busy;
  logic                                done;
  logic                                conflict;
  logic [CLAUSE_NUM_LOG-1:0]           conflict_clause;
  logic [VAR_NUM_LOG:0]                imp_count;

  modport master (
    output start, imp_valid, imp_var, imp_val, asg_valid, asg_val, fat_full,
    input  fat_en, fat_write, fat_in, fat_val, busy, done, conflict,
           conflict_clause, imp_count
  );

  modport slave (
    input  start, imp_valid, imp_var, imp_val, asg_valid, asg_val, fat_full,
    output fat_en, fat_write, fat_in, fat_val, busy, done, conflict,
           conflict_clause, imp_count
  );

endinterface

// File: rtl/imp_priority_encoder.sv
// rtl/imp_priority_encoder.sv - lowest-set-bit index of a request vector
//
// Purpose: combinational priority encoder, lowest index wins.
// Ports:
//   req_i - request vector (N bits)
//   idx_o - index of the lowest set bit (0 when none set)
//   any_o - at least one request bit set
module imp_priority_encoder #(
  parameter int N   = bcp_pkg::CLAUSE_NUM,
  parameter int LOG = bcp_pkg::CLAUSE_NUM_LOG
) (
  input  logic [N-1:0]   req_i,
  output logic [LOG-1:0] idx_o,
  output logic           any_o
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = LOG'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/implication_writer.sv
// rtl/implication_writer.sv - serializes per-clause unit implications into FAT writes
//
// Purpose: after a BCP evaluation round, latches the clause implications and
//   drains them lowest clause first, one per cycle: unassigned variables are
//   written to the FAT, agreeing duplicates are dropped, disagreeing ones end
//   the round with a conflict.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - implication_writer_if.slave (implications, assignment, FAT port, status)
module implication_writer
  import bcp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  implication_writer_if.slave  bus
);

  iw_state_t                     state_q, state_d;
  logic [CLAUSE_NUM-1:0]         pending_q, pending_d;
  var_idx_t [CLAUSE_NUM-1:0]     imp_var_q, imp_var_d;
  logic [CLAUSE_NUM-1:0]         imp_val_q, imp_val_d;
  // Assignments made during this round, shadowing asg_valid/asg_val.
  logic [VAR_NUM-1:0]            loc_valid_q, loc_valid_d;
  logic [VAR_NUM-1:0]            loc_val_q, loc_val_d;
  logic                          fat_en_q, fat_en_d;
  var_idx_t                      fat_in_q, fat_in_d;
  logic                          fat_val_q, fat_val_d;
  logic [CLAUSE_NUM_LOG-1:0]     conflict_clause_q, conflict_clause_d;
  logic [VAR_NUM_LOG:0]          imp_count_q, imp_count_d;

  logic [CLAUSE_NUM_LOG-1:0]     head_idx;
  logic                          head_any;
  var_idx_t                      head_var;
  logic                          head_val;
  logic                          eff_assigned;
  logic                          eff_value;

  imp_priority_encoder #(
    .N   (CLAUSE_NUM),
    .LOG (CLAUSE_NUM_LOG)
  ) u_head_enc (
    .req_i (pending_q),
    .idx_o (head_idx),
    .any_o (head_any)
  );

  assign head_var     = imp_var_q[head_idx];
  assign head_val     = imp_val_q[head_idx];
  assign eff_assigned = bus.asg_valid[head_var] | loc_valid_q[head_var];
  assign eff_value    = loc_valid_q[head_var] ? loc_val_q[head_var]
                                              : bus.asg_val[head_var];

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    imp_var_d         = imp_var_q;
    imp_val_d         = imp_val_q;
    loc_valid_d       = loc_valid_q;
    loc_val_d         = loc_val_q;
    fat_en_d          = 1'b0;
    fat_in_d          = fat_in_q;
    fat_val_d         = fat_val_q;
    conflict_clause_d = conflict_clause_q;
    imp_count_d       = imp_count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_d         = bus.imp_valid;
          imp_var_d         = bus.imp_var;
          imp_val_d         = bus.imp_val;
          loc_valid_d       = '0;
          imp_count_d       = '0;
          conflict_clause_d = '0;
          state_d           = (bus.imp_valid == '0) ? DONE : DRAIN;
        end
      end

      DRAIN: begin
        if (!head_any) begin
          state_d = DONE;
        end else if (!eff_assigned) begin
          // Unassigned: write when the FAT has room, otherwise hold everything.
          if (!bus.fat_full) begin
            fat_en_d              = 1'b1;
            fat_in_d              = head_var;
            fat_val_d             = head_val;
            loc_valid_d[head_var] = 1'b1;
            loc_val_d[head_var]   = head_val;
            pending_d[head_idx]   = 1'b0;
            imp_count_d           = imp_count_q + {{VAR_NUM_LOG{1'b0}}, 1'b1};
          end
        end else if (eff_value == head_val) begin
          pending_d[head_idx] = 1'b0;
        end else begin
          conflict_clause_d = head_idx;
          state_d           = CONFLICT;
        end

        if (state_d == DRAIN && pending_d == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      CONFLICT: begin
        pending_d = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      pending_q         <= '0;
      imp_var_q         <= '0;
      imp_val_q         <= '0;
      loc_valid_q       <= '0;
      loc_val_q         <= '0;
      fat_en_q          <= 1'b0;
      fat_in_q          <= '0;
      fat_val_q         <= 1'b0;
      conflict_clause_q <= '0;
      imp_count_q       <= '0;
    end else begin
      state_q           <= state_d;
      pending_q         <= pending_d;
      imp_var_q         <= imp_var_d;
      imp_val_q         <= imp_val_d;
      loc_valid_q       <= loc_valid_d;
      loc_val_q         <= loc_val_d;
      fat_en_q          <= fat_en_d;
      fat_in_q          <= fat_in_d;
      fat_val_q         <= fat_val_d;
      conflict_clause_q <= conflict_clause_d;
      imp_count_q       <= imp_count_d;
    end
  end

  assign bus.fat_en          = fat_en_q;
  assign bus.fat_write       = fat_en_q;
  assign bus.fat_in          = fat_in_q;
  assign bus.fat_val         = fat_val_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = (state_q == DONE);
  assign bus.conflict        = (state_q == CONFLICT);
  assign bus.conflict_clause = conflict_clause_q;
  assign bus.imp_count       = imp_count_q;

endmodule

// File: doc/implication_writer.md
Name: implication_writer

Overview:
- Producer side of the force-assign table (FAT) in the BCP unit.
- After a BCP evaluation round, collects per-clause unit implications (variable, forced value) and serializes them into FAT writes, one per cycle.
- Drops duplicate implications and detects conflicting implications or conflicts with the current assignment.
- Reports completion or conflict to the BCP controller.

Parameters:
- VAR_NUM, 8: number of variables.
- VAR_NUM_LOG, 3: variable index width.
- CLAUSE_NUM, 8: number of clause evaluators feeding implications.
- CLAUSE_NUM_LOG, 3: clause index width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: pulse; latch implications and begin a round; sampled only in IDLE.
- imp_valid, input, CLAUSE_NUM: bit k = clause k is unit and produces an implication.
- imp_var, input, CLAUSE_NUM*VAR_NUM_LOG: flattened; slice k is the implied variable of clause k.
- imp_val, input, CLAUSE_NUM: forced value for clause k.
- asg_valid, input, VAR_NUM: variable currently assigned; stable for the whole round.
- asg_val, input, VAR_NUM: current value of assigned variables.
- fat_full, input, 1: FAT cannot accept a write this cycle (stall).
- fat_en, output, 1: FAT access strobe.
- fat_write, output, 1: write qualifier, equal to fat_en.
- fat_in, output, VAR_NUM_LOG: variable index being written.
- fat_val, output, 1: forced value being written.
- busy, output, 1: state != IDLE.
- done, output, 1: one-cycle pulse, round finished with no conflict.
- conflict, output, 1: one-cycle pulse, conflict found.
- conflict_clause, output, CLAUSE_NUM_LOG: clause index that caused the conflict; held until the next start.
- imp_count, output, VAR_NUM_LOG+1: FAT writes issued this round; held until the next start.

Behaviour:
- Reset (async, immediate): state IDLE.
  - All outputs 0.
  - pending, loc_valid and loc_val cleared.
  - Reset mid-round aborts the round with no further fat_en.
- FSM states: IDLE, DRAIN, DONE, CONFLICT.
- IDLE with start=1 at an edge:
  - pending <= imp_valid; imp_var and imp_val are registered.
  - loc_valid <= 0; imp_count <= 0; conflict_clause <= 0.
  - Next state is DRAIN, or DONE if imp_valid == 0.
  - start is ignored outside IDLE.
- DRAIN, each cycle:
  - k = lowest set bit of pending (imp_priority_encoder), v = var[k], b = val[k].
  - Effective assignment: assigned = asg_valid[v] | loc_valid[v]; value = loc_valid[v] ? loc_val[v] : asg_val[v].
  - Unassigned and !fat_full: next cycle fat_en = fat_write = 1, fat_in = v, fat_val = b.
    - Set loc_valid[v] and loc_val[v] = b; clear pending[k]; increment imp_count.
  - Unassigned and fat_full: stall. No write and no state change; fat_en = 0 next cycle.
  - Assigned with value == b: duplicate. Clear pending[k]; no write.
  - Assigned with value != b: go to CONFLICT; conflict_clause <= k; no write.
- fat_en and fat_write are registered, high for exactly one cycle per write. fat_in and fat_val are held between writes.
- When the edge that clears the last pending bit occurs without conflict, next state is DONE.
  - done is high during DONE for one cycle, concurrent with the final fat_en pulse if that edge issued a write.
  - Then IDLE.
- CONFLICT: conflict high for one cycle, then IDLE. Remaining pending entries are discarded. done is never asserted.
- Throughput: one pending clause per DRAIN cycle, whether written or dropped.
  - With no stalls, N pending clauses take N DRAIN cycles plus 1 DONE cycle.
- imp_count cannot exceed VAR_NUM, because each variable is written at most once per round; no wrap.
- Two clauses implying the same variable:
  - Same value: the lower index writes, the higher is dropped.
  - Opposite value: conflict reported on the higher index.

Decomposition:
- Shared package bcp_pkg holds:
  - VAR_NUM, VAR_NUM_LOG, CLAUSE_NUM, CLAUSE_NUM_LOG;
  - FSM enum iw_state_t (IDLE, DRAIN, DONE, CONFLICT);
  - typedef var_idx_t [VAR_NUM_LOG-1:0].
- One sub-module: imp_priority_encoder.
  - Combinational lowest-set-bit index of CLAUSE_NUM bits, plus an any-set flag.
  - Reused by other BCP blocks.

Test Plan:
- Basic round: start with imp_valid=8'b0000_0101, clause0 implies var3=1, clause2 implies var5=0, asg_valid=0, fat_full=0.
  - Expect fat_en pulses with (fat_in=3, fat_val=1) then (fat_in=5, fat_val=0) on consecutive cycles.
  - Expect done with the second pulse and imp_count=2.
- Duplicate: clauses 1 and 4 both imply var2=1.
  - Expect a single write (fat_in=2), imp_count=1, done=1, conflict never asserted.
- Internal conflict: clause 0 implies var6=1, clause 3 implies var6=0.
  - Expect one write for var6, then conflict=1 with conflict_clause=3, no done.
- Assignment conflict and empty round:
  - asg_valid[4]=1, asg_val[4]=0, clause 7 implies var4=1: expect no write, conflict_clause=7.
  - start with imp_valid=0: expect done one cycle after start, imp_count=0.
- Stall: fat_full=1 for 3 cycles at round start with one implication (var1=1).
  - Expect fat_en=0 throughout the stall, then exactly one write with fat_in=1, then done.
- Reset mid-round: 4 implications pending, assert rst after the second fat_en.
  - Expect all outputs 0 immediately and no further fat_en.
  - A subsequent start behaves as a fresh round.
